// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types for the intersection phase scheduler: lamp codes, FSM states, road ids.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package traffic_phase_scheduler_pkg;

  // Lamp driver encoding, common to both roads.
  typedef enum logic [1:0] {
    LT_GREEN  = 2'd0,
    LT_YELLOW = 2'd1,
    LT_RED    = 2'd2,
    LT_OFF    = 2'd3
  } lamp_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_G1   = 3'd1,
    ST_Y1   = 3'd2,
    ST_AR1  = 3'd3,
    ST_G2   = 3'd4,
    ST_Y2   = 3'd5,
    ST_AR2  = 3'd6,
    ST_WALK = 3'd7
  } state_t;

  typedef enum logic {
    ROAD1 = 1'b0,
    ROAD2 = 1'b1
  } road_t;

  typedef struct packed {
    lamp_t l1;
    lamp_t l2;
  } lamps_t;

  function automatic state_t green_of(road_t r);
    return (r == ROAD1) ? ST_G1 : ST_G2;
  endfunction

  // Lamp pair shown while in a given state; all-red unless a road is green/yellow.
  function automatic lamps_t lamps_of(state_t s);
    lamps_t v;
    v.l1 = LT_RED;
    v.l2 = LT_RED;
    case (s)
      ST_IDLE: begin
        v.l1 = LT_OFF;
        v.l2 = LT_OFF;
      end
      ST_G1:   v.l1 = LT_GREEN;
      ST_Y1:   v.l1 = LT_YELLOW;
      ST_G2:   v.l2 = LT_GREEN;
      ST_Y2:   v.l2 = LT_YELLOW;
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Bundle of request inputs and lamp/ack outputs of the phase scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; requests are levels/pulses, outputs are free-running lamp states.
//   master: drives START, ped_req1/2, emg_req; observes l1, l2, walk1/2, ped_ack1/2, emg_act
//   slave : the scheduler itself
interface traffic_phase_scheduler_if;
  logic       START;
  logic       ped_req1;
  logic       ped_req2;
  logic [1:0] emg_req;
  logic [1:0] l1;
  logic [1:0] l2;
  logic       walk1;
  logic       walk2;
  logic       ped_ack1;
  logic       ped_ack2;
  logic       emg_act;

  modport master (
    output START, ped_req1, ped_req2, emg_req,
    input  l1, l2, walk1, walk2, ped_ack1, ped_ack2, emg_act
  );

  modport slave (
    input  START, ped_req1, ped_req2, emg_req,
    output l1, l2, walk1, walk2, ped_ack1, ped_ack2, emg_act
  );
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, stops at limit, flags limit reached.
// Latency: done is combinational from the count register (count updates one cycle after enable).
// Backpressure: none.
//   clk/rst : clock, async active-high reset
//   clear   : zero the count (wins over enable)
//   enable  : advance by one per cycle, saturating at limit
//   limit   : last count value of the phase (phase length - 1)
//   done    : count == limit
module traffic_phase_scheduler_phase_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          done
);
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == limit);
endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with pedestrian WALK insertion and emergency preemption.
// Latency: all outputs registered, updating on the same edge as the phase state.
// Backpressure: none; ped requests are latched until served, emg_req is sampled as a level.
//   clk, RST : clock, async active-high reset
//   bus      : slave side of traffic_phase_scheduler_if (START, ped_req*, emg_req in;
//              l1, l2, walk*, ped_ack*, emg_act out)
module traffic_phase_scheduler
  import traffic_phase_scheduler_pkg::*;
#(
  parameter int CW       = 16,
  parameter int T_GREEN  = 50000,
  parameter int T_YELLOW = 10000,
  parameter int T_ALLRED = 2000,
  parameter int T_WALK   = 20000
) (
  input  logic clk,
  input  logic RST,
  traffic_phase_scheduler_if.slave bus
);
  localparam logic [CW-1:0] LIM_G = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] LIM_Y = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] LIM_A = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] LIM_W = CW'(T_WALK - 1);

  state_t        state, next_state;
  road_t         next_road, next_road_nxt;
  logic          lat1, lat2, lat1_nxt, lat2_nxt;
  lamps_t        lamps_q, lamps_nxt;
  logic          walk1_q, walk2_q, walk1_nxt, walk2_nxt;
  logic          ack1_q, ack2_q, ack1_nxt, ack2_nxt;
  logic          emg_q, emg_nxt;
  logic          emg_vld;
  road_t         emg_road;
  state_t        emg_green;
  logic [CW-1:0] limit;
  logic          done;
  logic          tmr_clear;
  logic          tmr_enable;
  logic          walk_entry;

  // Phase length of the current state. The timer saturates here, which is what
  // holds a preempted green at its last count.
  always_comb begin
    limit = '0;
    case (state)
      ST_G1, ST_G2:   limit = LIM_G;
      ST_Y1, ST_Y2:   limit = LIM_Y;
      ST_AR1, ST_AR2: limit = LIM_A;
      ST_WALK:        limit = LIM_W;
      default:        limit = '0;
    endcase
  end

  traffic_phase_scheduler_phase_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (RST),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .limit  (limit),
    .done   (done)
  );

  // bit0 wins when both preemption bits are set
  always_comb begin
    emg_vld   = bus.emg_req[0] | bus.emg_req[1];
    emg_road  = bus.emg_req[0] ? ROAD1 : ROAD2;
    emg_green = green_of(emg_road);
  end

  // Next-state and registered-output values
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.START) next_state = ST_G1;
      ST_G1: begin
        if (emg_vld && (emg_road == ROAD2))      next_state = ST_Y1;
        else if (done && !emg_vld)               next_state = ST_Y1;
      end
      ST_G2: begin
        if (emg_vld && (emg_road == ROAD1))      next_state = ST_Y2;
        else if (done && !emg_vld)               next_state = ST_Y2;
      end
      ST_Y1: if (done) next_state = ST_AR1;
      ST_Y2: if (done) next_state = ST_AR2;
      ST_AR1: begin
        if (done) begin
          if (emg_vld)           next_state = emg_green;
          else if (lat1 || lat2) next_state = ST_WALK;
          else                   next_state = ST_G2;
        end
      end
      ST_AR2: begin
        if (done) begin
          if (emg_vld)           next_state = emg_green;
          else if (lat1 || lat2) next_state = ST_WALK;
          else                   next_state = ST_G1;
        end
      end
      ST_WALK: begin
        if (done) next_state = emg_vld ? emg_green : green_of(next_road);
      end
      default: next_state = ST_IDLE;
    endcase

    tmr_clear  = (next_state != state);
    tmr_enable = (state != ST_IDLE);
    walk_entry = (next_state == ST_WALK) && (state != ST_WALK);

    // After WALK, serve the road that did not just have its green
    next_road_nxt = next_road;
    if (walk_entry) next_road_nxt = (state == ST_AR1) ? ROAD2 : ROAD1;

    // A request arriving on the acceptance edge survives the clear
    lat1_nxt  = (walk_entry ? 1'b0 : lat1) | bus.ped_req1;
    lat2_nxt  = (walk_entry ? 1'b0 : lat2) | bus.ped_req2;
    ack1_nxt  = walk_entry & lat1;
    ack2_nxt  = walk_entry & lat2;
    walk1_nxt = (next_state == ST_WALK) & (walk_entry ? lat1 : walk1_q);
    walk2_nxt = (next_state == ST_WALK) & (walk_entry ? lat2 : walk2_q);

    lamps_nxt = lamps_of(next_state);

    // Active while heading for the target green, or while sitting in it past its
    // normal end (same state, timer already at its limit).
    emg_nxt = emg_vld && (next_state != ST_IDLE) &&
              ((next_state != emg_green) || ((state == next_state) && done));
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      next_road <= ROAD1;
      lat1      <= 1'b0;
      lat2      <= 1'b0;
      lamps_q   <= '{l1: LT_OFF, l2: LT_OFF};
      walk1_q   <= 1'b0;
      walk2_q   <= 1'b0;
      ack1_q    <= 1'b0;
      ack2_q    <= 1'b0;
      emg_q     <= 1'b0;
    end else begin
      state     <= next_state;
      next_road <= next_road_nxt;
      lat1      <= lat1_nxt;
      lat2      <= lat2_nxt;
      lamps_q   <= lamps_nxt;
      walk1_q   <= walk1_nxt;
      walk2_q   <= walk2_nxt;
      ack1_q    <= ack1_nxt;
      ack2_q    <= ack2_nxt;
      emg_q     <= emg_nxt;
    end
  end

  assign bus.l1       = lamps_q.l1;
  assign bus.l2       = lamps_q.l2;
  assign bus.walk1    = walk1_q;
  assign bus.walk2    = walk2_q;
  assign bus.ped_ack1 = ack1_q;
  assign bus.ped_ack2 = ack2_q;
  assign bus.emg_act  = emg_q;
endmodule
